spart_tx_gen: RTL and testbench
===============================

SPART_TX_GEN -- requirements
Module: spart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  request to push wr_data into FIFO.
REQ-006 SHALL have port wr_data  input  DATA_W  byte to transmit, LSB sent first.
REQ-007 SHALL have port divisor  input  16  baud divisor; each bit lasts divisor+1 clk cycles.
REQ-008 SHALL have port parity_en  input  1  append parity bit after data.
REQ-009 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port two_stop  input  1  1 = two stop bits, 0 = one.
REQ-011 SHALL have port tbr  output  1  transmit buffer ready: FIFO not full.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse on wr_en while FIFO full.
REQ-013 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  entries currently queued.
REQ-014 SHALL have port tx_busy  output  1  high whenever FSM is not IDLE.
REQ-015 SHALL have port txd  output  1  serial line, idle high, registered.

Function
REQ-016 SHALL accept a push when wr_en=1 and fifo_count<FIFO_DEPTH at the same edge; count increments next cycle.
REQ-017 SHALL drop wr_en while full, leave FIFO unchanged, and pulse overflow for exactly that cycle.
REQ-018 SHALL allow simultaneous push and pop; count unchanged, order preserved, push permitted when full only if a pop occurs the same edge.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL, in IDLE with fifo_count>0, pop the head entry, latch divisor/parity_en/parity_odd/two_stop and enter START; frame config is held constant for the whole frame.
REQ-021 SHALL produce txd=0 for START, data LSB-first for DATA_W bits in DATA, parity bit in PARITY (skipped if parity_en=0), txd=1 for 1 or 2 bit times in STOP.
REQ-022 SHALL compute parity as XOR of DATA_W data bits, inverted when parity_odd=1.
REQ-023 SHALL time each bit with a down-counter loaded with latched divisor; bit ends on the cycle the counter equals 0; divisor=0 gives one clk per bit.
REQ-024 SHALL, at end of last stop bit, go directly to START (no idle cycle) if fifo_count>0, else to IDLE.
REQ-025 SHALL have latency: word pushed at edge N into empty FIFO with FSM IDLE -> txd falls at edge N+2.
REQ-026 SHALL hold txd=1 in IDLE; tx_busy=0 only in IDLE.
REQ-027 SHALL ignore changes on divisor and mode inputs mid-frame; they take effect at next frame start.
REQ-028 SHALL frame length equal 1+DATA_W+parity_en+1+two_stop bit times.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set FSM=IDLE, txd=1, tx_busy=0, fifo_count=0, tbr=1, overflow=0, bit/baud counters cleared.
REQ-030 SHALL abort any frame in progress on reset; txd high the cycle after the reset edge, queued data discarded.
REQ-031 SHALL ignore wr_en during a cycle with rst=1.

Verification
REQ-032 DATA_W=8, divisor=3, no parity, one stop, push 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each held 4 clk, 40 clk total, tx_busy low after.
REQ-033 parity_en=1, parity_odd=0, push 0x07 -> parity bit 1; parity_odd=1 -> 0; frame 11 bit times.
REQ-034 FIFO_DEPTH=4, divisor=0, push 5 words back-to-back -> tbr low after 4th (less one if pop occurred), overflow pulses on dropped write, frames emitted contiguous with no idle cycle.
REQ-035 two_stop=1, divisor=1 -> stop high for 4 clk; change divisor to 9 mid-frame -> current frame unaffected, next frame 10 clk/bit.
REQ-036 rst asserted during DATA bit 3 -> txd=1, fifo_count=0, tx_busy=0 next cycle; new push after release transmits correctly.

Source files
------------

// File: rtl/spart_tx_gen.sv
// spart_tx_gen: FIFO-buffered asynchronous serial transmitter.
// Words are queued in a small power-of-two FIFO and sent as
// start + DATA_W data bits (LSB first) + optional parity + 1 or 2 stop bits.
// The frame configuration is captured when a word is popped, so it stays
// constant for the whole frame.
module spart_tx_gen #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [15:0]                   divisor,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  output logic                          tbr,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity bit: XOR of the data bits, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;

  logic [2:0]        r_state;
  logic [15:0]       r_baud;
  logic [3:0]        r_bit_cnt;
  logic              r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [15:0]       r_div;
  logic              r_par_en;
  logic              r_two_stop;
  logic              r_txd;

  logic              w_full;
  logic              w_bit_end;
  logic              w_frame_end;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_head;
  logic              w_txd_next;

  assign w_full      = (r_count == C_FULL);
  assign w_bit_end   = (r_baud == 16'd0);
  // The last stop bit ends the frame; a second stop bit is pending while r_stop_cnt is 0.
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (!r_two_stop || r_stop_cnt);
  assign w_pop       = (r_count != {CW{1'b0}}) && ((r_state == S_IDLE) || w_frame_end);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push      = wr_en && (!w_full || w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  // FIFO storage, pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + P_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      r_ovf <= wr_en && !w_push;
    end
  end

  // Frame sequencer: bit timing, data shifting and stop-bit counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= {DATA_W{1'b0}};
      r_par      <= 1'b0;
      r_div      <= 16'd0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (w_pop) begin
      r_state    <= S_START;
      r_baud     <= divisor;
      r_div      <= divisor;
      r_par_en   <= parity_en;
      r_two_stop <= two_stop;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= w_head;
      r_par      <= parity_bit(w_head, parity_odd);
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= 16'd0;
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_baud    <= r_div;
            r_bit_cnt <= 4'd0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud  <= r_div;
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_state    <= r_par_en ? S_PARITY : S_STOP;
              r_stop_cnt <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_baud     <= r_div;
            r_stop_cnt <= 1'b0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_two_stop && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
              r_baud     <= r_div;
            end else begin
              r_state <= S_IDLE;
              r_baud  <= 16'd0;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= 16'd0;
        end
      endcase
    end
  end

  // Line level implied by the current sequencer state.
  always_comb begin
    w_txd_next = 1'b1;
    case (r_state)
      S_IDLE:   w_txd_next = 1'b1;
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = r_shift[0];
      S_PARITY: w_txd_next = r_par;
      S_STOP:   w_txd_next = 1'b1;
      default:  w_txd_next = 1'b1;
    endcase
  end

  // Registered serial output; forced to the idle level on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd <= 1'b1;
    end else begin
      r_txd <= w_txd_next;
    end
  end

  assign txd        = r_txd;
  assign tx_busy    = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign tbr        = !w_full;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_spart_tx_gen.sv
// Bench for spart_tx_gen: queue-based frame model checked every cycle,
// plus directed scenarios with hand-derived waveforms.
module tb_spart_tx_gen;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [15:0] divisor;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        tbr;
  logic        overflow;
  logic [2:0]  fifo_count;
  logic        tx_busy;
  logic        txd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spart_tx_gen #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .divisor(divisor),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tbr(tbr), .overflow(overflow), .fifo_count(fifo_count),
    .tx_busy(tx_busy), .txd(txd)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a word queue plus a queue of future line levels, one per clock.
  initial begin : model
    logic [7:0] mq[$];
    logic       lq[$];
    logic       fb[$];
    logic       e_txd;
    logic       e_ovf;
    logic [7:0] d;
    e_txd = 1'b1;
    e_ovf = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        lq.delete();
        e_txd = 1'b1;
        e_ovf = 1'b0;
      end else begin
        if (lq.size() > 0) e_txd = lq.pop_front();
        else e_txd = 1'b1;
        if (lq.size() == 0 && mq.size() > 0) begin
          d = mq.pop_front();
          fb.delete();
          fb.push_back(1'b0);
          for (int i = 0; i < DW; i++) fb.push_back(d[i]);
          if (parity_en) fb.push_back((^d) ^ parity_odd);
          fb.push_back(1'b1);
          if (two_stop) fb.push_back(1'b1);
          foreach (fb[b]) repeat (int'(divisor) + 1) lq.push_back(fb[b]);
        end
        e_ovf = 1'b0;
        if (wr_en) begin
          if (mq.size() < DEPTH) mq.push_back(wr_data);
          else e_ovf = 1'b1;
        end
      end
      @(negedge clk);
      check("txd", txd, e_txd);
      check("tx_busy", tx_busy, lq.size() != 0);
      check("fifo_count", fifo_count, mq.size());
      check("tbr", tbr, mq.size() < DEPTH);
      check("overflow", overflow, e_ovf);
    end
  end

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Waits (bounded) for the start bit; returns the number of negedges waited.
  task automatic wait_fall(output int g);
    g = 0;
    while (txd !== 1'b0 && g < 300) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (tx_busy !== 1'b0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("idle_bound", g < 500, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    logic a5w [10];
    logic w3c [10];
    int   g;
    int   cnt;
    a5w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    w3c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; divisor = 16'd3;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tbr", tbr, 1'b1);
    check("rst_count", fifo_count, 3'd0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5, divisor 3, 8N1: 10 bits x 4 clk.
    push(8'hA5);
    wait_fall(g);
    check("latency_a5", g, 2);
    for (int i = 0; i < 40; i++) begin
      check("a5_bit", txd, a5w[i / 4]);
      if (i == 38) check("a5_busy_end-1", tx_busy, 1'b1);
      if (i == 39) check("a5_busy_end", tx_busy, 1'b0);
      @(negedge clk);
    end
    check("a5_after_txd", txd, 1'b1);
    check("a5_after_busy", tx_busy, 1'b0);
    wait_idle();

    // 0x07 with even then odd parity, divisor 0: 11 bit times.
    divisor = 16'd0; parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    wait_fall(g);
    check("latency_even", g, 2);
    for (int i = 0; i < 12; i++) begin
      if (i == 9) check("even_par", txd, 1'b1);
      if (i == 9) check("even_len_busy", tx_busy, 1'b1);
      if (i == 10) check("even_len_done", tx_busy, 1'b0);
      @(negedge clk);
    end
    wait_idle();
    parity_odd = 1'b1;
    push(8'h07);
    wait_fall(g);
    check("latency_odd", g, 2);
    for (int i = 0; i < 12; i++) begin
      if (i == 9) check("odd_par", txd, 1'b0);
      if (i == 10) check("odd_len_done", tx_busy, 1'b0);
      @(negedge clk);
    end
    wait_idle();

    // Six back-to-back writes into a depth-4 FIFO, divisor 0.
    parity_en = 1'b0; parity_odd = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1;
      wr_data = 8'h30 + 8'(k * 17);
      @(negedge clk);
      if (tx_busy) cnt++;
      if (k == 4) check("full_tbr", tbr, 1'b0);
      if (k == 4) check("full_count", fifo_count, 3'd4);
      if (k == 5) check("ovf_pulse", overflow, 1'b1);
      if (k == 5) check("ovf_count", fifo_count, 3'd4);
    end
    wr_en = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      if (g == 0) check("ovf_one_cycle", overflow, 1'b0);
      if (tx_busy) cnt++;
      g++;
    end while (tx_busy && g < 500);
    check("contig_busy_cycles", cnt, 50);
    wait_idle();

    // Two stop bits at divisor 1; divisor changes to 9 mid-frame.
    two_stop = 1'b1; divisor = 16'd1;
    push(8'h00);
    push(8'h01);
    wait_fall(g);
    check("fall_bound_2stop", g < 300, 1'b1);
    for (int i = 0; i < 46; i++) begin
      if (i == 5) divisor = 16'd9;
      if (i == 17) check("d7_low", txd, 1'b0);
      if (i >= 18 && i <= 21) check("stop2_high", txd, 1'b1);
      if (i == 22) check("next_start", txd, 1'b0);
      if (i == 31) check("start_10clk", txd, 1'b0);
      if (i == 32) check("bit0_after10", txd, 1'b1);
      @(negedge clk);
    end
    wait_idle();

    // Reset during data bit 3, with a second word queued.
    two_stop = 1'b0; divisor = 16'd3;
    push(8'hFF);
    push(8'h55);
    wait_fall(g);
    check("fall_bound_rst", g < 300, 1'b1);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hAA;
    @(negedge clk);
    check("abort_txd", txd, 1'b1);
    check("abort_count", fifo_count, 3'd0);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_tbr", tbr, 1'b1);
    rst = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check("post_rst_quiet", tx_busy, 1'b0);
    divisor = 16'd0;
    push(8'h3C);
    wait_fall(g);
    check("latency_3c", g, 2);
    for (int i = 0; i < 10; i++) begin
      check("3c_bit", txd, w3c[i]);
      @(negedge clk);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
